vga_sync_gen: RTL and testbench

//   Generates VGA 640x480@60 raster timing from the 100 MHz system clock.

---
 rtl/vga_sync_gen_pkg.sv | 31 +++
 rtl/vga_pix_div.sv | 44 ++++
 rtl/vga_sync_gen.sv | 132 +++++++++++++
 tb/tb_vga_sync_gen.sv | 134 +++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA 640x480@60 timing defaults and small decode helpers for vga_sync_gen and overlay layers.
// The optional frame counter is enabled by defining VGA_SYNC_FRAME_CNT_EN.
package vga_sync_gen_pkg;

    localparam int CNT_W       = 10;
    localparam int FRAME_CNT_W = 16;

    localparam int CLK_DIV     = 4;
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC_END  = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 784;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC_END  = 2;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 515;

    // Origin of the visible window in raster coordinates, used by overlay controllers.
    localparam int ACTIVE_X0   = H_ACT_START;
    localparam int ACTIVE_Y0   = V_ACT_START;

    // Half-open window test: lo <= val < hi.
    function automatic logic in_window(
        input logic [CNT_W-1:0] val,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: counts system clocks 0..CLK_DIV-1 and flags the advancing cycle.
// adv is the combinational advance strobe; pix_tick is its registered copy on the same edge.
module vga_pix_div
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV = vga_sync_gen_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic adv,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             pix_tick_q;

    assign adv      = (div_q == DIV_W'(CLK_DIV - 1));
    assign pix_tick = pix_tick_q;

    // Next divider value: wrap on the advancing cycle.
    always_comb begin
        div_d = div_q;
        if (adv) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Divider and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            pix_tick_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            pix_tick_q <= adv;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters, registered sync/bright decode, frame pulse.
// Define VGA_SYNC_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV     = vga_sync_gen_pkg::CLK_DIV,
    parameter int H_TOTAL     = vga_sync_gen_pkg::H_TOTAL,
    parameter int H_SYNC_END  = vga_sync_gen_pkg::H_SYNC_END,
    parameter int H_ACT_START = vga_sync_gen_pkg::H_ACT_START,
    parameter int H_ACT_END   = vga_sync_gen_pkg::H_ACT_END,
    parameter int V_TOTAL     = vga_sync_gen_pkg::V_TOTAL,
    parameter int V_SYNC_END  = vga_sync_gen_pkg::V_SYNC_END,
    parameter int V_ACT_START = vga_sync_gen_pkg::V_ACT_START,
    parameter int V_ACT_END   = vga_sync_gen_pkg::V_ACT_END
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             bright,
    output logic             hSync,
    output logic             vSync,
    output logic             pix_tick,
    output logic             frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 2) begin : g_div_chk
        $error("vga_sync_gen: CLK_DIV must be >= 2");
    end

    logic             adv;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             bright_q, bright_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .pix_tick (pix_tick)
    );

    // Next counts, and decode from those next counts so outputs move with zero skew.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        if (adv) begin
            if (h_q == CNT_W'(H_TOTAL - 1)) begin
                h_d = '0;
                if (v_q == CNT_W'(V_TOTAL - 1)) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end else begin
            h_d = h_q;
        end
        hsync_d  = (h_d >= CNT_W'(H_SYNC_END));
        vsync_d  = (v_d >= CNT_W'(V_SYNC_END));
        bright_d = in_window(h_d, CNT_W'(H_ACT_START), CNT_W'(H_ACT_END)) &&
                   in_window(v_d, CNT_W'(V_ACT_START), CNT_W'(V_ACT_END));
    end

    // Counter and decoded-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            bright_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            bright_q      <= bright_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Frame counter steps on each frame pulse and wraps naturally.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign hCount      = h_q;
    assign vCount      = v_q;
    assign bright      = bright_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shrunken raster; expected outputs derive from
// the number of clocks since reset. Honours VGA_SYNC_FRAME_CNT_EN when defined.
module tb_vga_sync_gen;

    localparam int CD  = 3;
    localparam int HT  = 40;
    localparam int HSE = 5;
    localparam int HAS = 8;
    localparam int HAE = 36;
    localparam int VT  = 20;
    localparam int VSE = 2;
    localparam int VAS = 4;
    localparam int VAE = 17;
    localparam int NCYC = 9000;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        br;
        logic        hs;
        logic        vs;
        logic        tick;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hCount, vCount;
    logic        bright, hSync, vSync, pix_tick, frame_start;
    logic [15:0] fc_obs;

    obs_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    assign fc_obs = frame_cnt;
`else
    assign fc_obs = 16'd0;
`endif

    vga_sync_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC_END(HSE), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_TOTAL(VT), .V_SYNC_END(VSE), .V_ACT_START(VAS), .V_ACT_END(VAE)
    ) dut (
        .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount), .bright(bright),
        .hSync(hSync), .vSync(vSync), .pix_tick(pix_tick), .frame_start(frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    // Reference: everything follows from n = clocks since the last reset edge.
    function automatic obs_t model(input int n);
        obs_t e;
        int ticks, p, h, v;
        ticks = n / CD;
        p     = ticks % (HT * VT);
        h     = p % HT;
        v     = p / HT;
        e.h    = 10'(h);
        e.v    = 10'(v);
        e.tick = (n > 0) && (n % CD == 0);
        e.fs   = e.tick && (p == 0);
        e.hs   = (h >= HSE);
        e.vs   = (v >= VSE);
        e.br   = (h >= HAS) && (h < HAE) && (v >= VAS) && (v < VAE);
`ifdef VGA_SYNC_FRAME_CNT_EN
        e.fc   = 16'((ticks / (HT * VT)) % 65536);
`else
        e.fc   = 16'd0;
`endif
        return e;
    endfunction

    // Monitor: compare every presented output against the queued expectation.
    always @(negedge clk) begin
        obs_t a, e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {hCount, vCount, bright, hSync, vSync, pix_tick, frame_start, fc_obs};
            compared = compared + 1;
            if (a !== e) begin
                mismatched = mismatched + 1;
                $display("FAIL raster t=%0t got h=%0d v=%0d br=%b hs=%b vs=%b tick=%b fs=%b fc=%0d required h=%0d v=%0d br=%b hs=%b vs=%b tick=%b fs=%b fc=%0d",
                         $time, a.h, a.v, a.br, a.hs, a.vs, a.tick, a.fs, a.fc,
                         e.h, e.v, e.br, e.hs, e.vs, e.tick, e.fs, e.fc);
            end
        end
    end

    // Driver: reset for 3 clocks, one reset inside both sync pulses, rare random resets.
    initial begin
        int   n;
        bit   r;
        bit   forced;
        obs_t cur;
        n      = 0;
        forced = 1'b0;
        cur    = model(0);
        rst    = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc < 3) begin
                r = 1'b1;
            end else if (!forced && cur.h == 10'd2 && cur.v == 10'd1 && !cur.tick) begin
                r      = 1'b1;
                forced = 1'b1;
            end else begin
                r = ($urandom_range(0, 2999) == 0);
            end
            rst = r;
            n   = r ? 0 : n + 1;
            cur = model(n);
            @(posedge clk);
            sb.push_back(cur);
            #1;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL drain got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
